// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// field values and ALU operation codes (also used by the ALU itself).
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_e;

  // Which kind of ALU decode the current state needs.
  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_R   = 2'd1,
    CLS_I   = 2'd2,
    CLS_BR  = 2'd3
  } alu_cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_BEQ = 3'b100;
  localparam logic [2:0] ALU_BNE = 3'b011;

  function automatic logic funct_known(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
           (f == FN_OR)  || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_control_unit_alu_dec.sv
// Combinational ALU-operation decoder: maps the state class plus opcode/funct to
// the 3-bit ALU operation and the immediate extension mode.
module alu_dec
  import mc_pkg::*;
#(
  parameter bit SUPPORT_IMM_LOGIC = 1'b1
) (
  input  alu_cls_e   cls,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       ext_zero
);

  always_comb begin
    alu_op   = ALU_ADD;
    ext_zero = 1'b0;
    case (cls)
      CLS_R: begin
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      CLS_I: begin
        case (opcode)
          OP_ANDI: if (SUPPORT_IMM_LOGIC) begin
            alu_op   = ALU_AND;
            ext_zero = 1'b1;
          end
          OP_ORI: if (SUPPORT_IMM_LOGIC) begin
            alu_op   = ALU_OR;
            ext_zero = 1'b1;
          end
          OP_SLTI: if (SUPPORT_IMM_LOGIC) alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      CLS_BR:  alu_op = (opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Main control FSM of the multi-cycle MIPS core: sequences fetch/decode/execute/
// memory/writeback and drives all datapath enables, selects and the ALU operation.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter bit SUPPORT_IMM_LOGIC = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic       run_q;
  logic       reg_dst_q, reg_dst_d;
  logic       op_legal;
  alu_cls_e   cls;
  logic [2:0] dec_alu_op;
  logic       dec_ext_zero;

  logic pc_write_c, branch_c, i_or_d_c, mem_read_c, mem_write_c, ir_write_c;
  logic reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c, done_c;
  logic [1:0] alu_src_b_c, pc_source_c;

  // run_q holds the machine idle for the first edge after reset release, so the
  // first active FETCH cycle starts after that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      run_q     <= 1'b0;
      reg_dst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= 1'b1;
      reg_dst_q <= reg_dst_d;
    end
  end

  always_comb begin
    case (opcode)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_ADDI: op_legal = 1'b1;
      OP_ANDI, OP_ORI, OP_SLTI: op_legal = SUPPORT_IMM_LOGIC;
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = S_FETCH;
    reg_dst_d = reg_dst_q;
    if (run_q) begin
      case (state_q)
        S_FETCH: state_d = S_DECODE;
        S_DECODE: begin
          if (!op_legal)                              state_d = S_FETCH;
          else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
          else if (opcode == OP_RTYPE)                state_d = S_EXEC_R;
          else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BRANCH;
          else if (opcode == OP_J)                    state_d = S_JUMP;
          else                                        state_d = S_EXEC_I;
        end
        S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_d = S_MEMWB;
        S_EXEC_R: begin
          if (funct_known(funct)) begin
            state_d   = S_ALUWB;
            reg_dst_d = 1'b1;
          end
        end
        S_EXEC_I: begin
          state_d   = S_ALUWB;
          reg_dst_d = 1'b0;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;
    i_or_d_c     = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'd0;
    pc_source_c  = 2'd0;
    done_c       = 1'b0;
    cls          = CLS_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        ir_write_c  = 1'b1;
        alu_src_b_c = 2'd1;
        pc_write_c  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b_c = 2'd3;
        done_c      = !op_legal;
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        done_c       = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        done_c      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_c = 1'b1;
        cls         = CLS_R;
        reg_dst_c   = 1'b1;
        done_c      = !funct_known(funct);
      end
      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        cls         = CLS_I;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = reg_dst_q;
        done_c      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        cls         = CLS_BR;
        pc_source_c = 2'd1;
        branch_c    = 1'b1;
        done_c      = 1'b1;
      end
      S_JUMP: begin
        pc_source_c = 2'd2;
        pc_write_c  = 1'b1;
        done_c      = 1'b1;
      end
      default: ;
    endcase
  end

  alu_dec #(.SUPPORT_IMM_LOGIC(SUPPORT_IMM_LOGIC)) u_alu_dec (
    .cls      (cls),
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (dec_alu_op),
    .ext_zero (dec_ext_zero)
  );

  // Everything is forced inactive while in reset or in the idle edge after it.
  assign pc_en      = run_q & (pc_write_c | (branch_c & zero));
  assign i_or_d     = run_q & i_or_d_c;
  assign mem_read   = run_q & mem_read_c;
  assign mem_write  = run_q & mem_write_c;
  assign ir_write   = run_q & ir_write_c;
  assign reg_dst    = run_q & reg_dst_c;
  assign mem_to_reg = run_q & mem_to_reg_c;
  assign reg_write  = run_q & reg_write_c;
  assign alu_src_a  = run_q & alu_src_a_c;
  assign alu_src_b  = run_q ? alu_src_b_c : 2'd0;
  assign pc_source  = run_q ? pc_source_c : 2'd0;
  assign ext_zero   = run_q & dec_ext_zero;
  assign alu_op     = run_q ? dec_alu_op : ALU_ADD;
  assign instr_done = run_q & done_c;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class cycle by cycle
// and compares state and control outputs against hand-derived values.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, ext_zero, instr_done;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  int total_cnt = 0;
  int pass_cnt  = 0;

  mc_control_unit #(.SUPPORT_IMM_LOGIC(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .pc_en      (pc_en),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_zero   (ext_zero),
    .pc_source  (pc_source),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b1; opcode = 6'b111111; funct = 6'd0; zero = 1'b0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (state !== 4'd0) $display("FAIL rst_state: got %0d want 0", state); else pass_cnt++;
    total_cnt++;
    if ({pc_en, mem_read, mem_write, ir_write, reg_write, instr_done} !== 6'b0)
      $display("FAIL rst_enables: got %b want 000000",
               {pc_en, mem_read, mem_write, ir_write, reg_write, instr_done});
    else pass_cnt++;
    total_cnt++;
    if (alu_op !== 3'b010) $display("FAIL rst_alu_op: got %b want 010", alu_op); else pass_cnt++;
    total_cnt++;
    if ({alu_src_b, pc_source, alu_src_a, i_or_d} !== 6'b0)
      $display("FAIL rst_selects: got %b want 000000", {alu_src_b, pc_source, alu_src_a, i_or_d});
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (state !== 4'd0 || mem_read !== 1'b1 || ir_write !== 1'b1 || pc_en !== 1'b1 || alu_src_b !== 2'd1)
      $display("FAIL first_fetch: got st=%0d mr=%b irw=%b pce=%b srcb=%0d want st=0 mr=1 irw=1 pce=1 srcb=1",
               state, mem_read, ir_write, pc_en, alu_src_b);
    else pass_cnt++;
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [5];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    opcode = 6'b100011; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (state !== exp_st[i]) $display("FAIL lw_state c%0d: got %0d want %0d", i, state, exp_st[i]);
      else pass_cnt++;
      total_cnt++;
      if (reg_write !== (i == 4) || mem_to_reg !== (i == 4) || instr_done !== (i == 4))
        $display("FAIL lw_wb c%0d: got rw=%b m2r=%b done=%b want %b", i, reg_write, mem_to_reg,
                 instr_done, (i == 4));
      else pass_cnt++;
      total_cnt++;
      if (mem_read !== (i == 0 || i == 3) || i_or_d !== (i == 3) || mem_write !== 1'b0)
        $display("FAIL lw_mem c%0d: got mr=%b iod=%b mw=%b", i, mem_read, i_or_d, mem_write);
      else pass_cnt++;
      if (i == 2) begin
        total_cnt++;
        if (alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || alu_op !== 3'b010)
          $display("FAIL lw_memadr: got a=%b b=%0d op=%b want a=1 b=2 op=010", alu_src_a, alu_src_b, alu_op);
        else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_st [4];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd5};
    opcode = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (state !== exp_st[i] || mem_write !== (i == 3) || instr_done !== (i == 3) || reg_write !== 1'b0)
        $display("FAIL sw c%0d: got st=%0d mw=%b done=%b rw=%b want st=%0d", i, state, mem_write,
                 instr_done, reg_write, exp_st[i]);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_r_sub();
    logic [3:0] exp_st [4];
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd8};
    opcode = 6'b000000; funct = 6'b100010;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (state !== exp_st[i]) $display("FAIL rsub_state c%0d: got %0d want %0d", i, state, exp_st[i]);
      else pass_cnt++;
      total_cnt++;
      if (reg_write !== (i == 3) || instr_done !== (i == 3))
        $display("FAIL rsub_wb c%0d: got rw=%b done=%b want %b", i, reg_write, instr_done, (i == 3));
      else pass_cnt++;
      if (i == 2) begin
        total_cnt++;
        if (alu_op !== 3'b110 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0)
          $display("FAIL rsub_exec: got op=%b a=%b b=%0d want op=110 a=1 b=0", alu_op, alu_src_a, alu_src_b);
        else pass_cnt++;
      end
      if (i == 3) begin
        total_cnt++;
        if (reg_dst !== 1'b1 || mem_to_reg !== 1'b0)
          $display("FAIL rsub_regdst: got rd=%b m2r=%b want rd=1 m2r=0", reg_dst, mem_to_reg);
        else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ori();
    logic [3:0] exp_st [4];
    exp_st = '{4'd0, 4'd1, 4'd7, 4'd8};
    opcode = 6'b001101;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (state !== exp_st[i]) $display("FAIL ori_state c%0d: got %0d want %0d", i, state, exp_st[i]);
      else pass_cnt++;
      if (i == 2) begin
        total_cnt++;
        if (alu_op !== 3'b001 || ext_zero !== 1'b1 || alu_src_b !== 2'd2)
          $display("FAIL ori_exec: got op=%b ez=%b b=%0d want op=001 ez=1 b=2", alu_op, ext_zero, alu_src_b);
        else pass_cnt++;
      end
      if (i == 3) begin
        total_cnt++;
        if (reg_write !== 1'b1 || reg_dst !== 1'b0 || instr_done !== 1'b1)
          $display("FAIL ori_wb: got rw=%b rd=%b done=%b want rw=1 rd=0 done=1", reg_write, reg_dst, instr_done);
        else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch(input logic [5:0] op, input logic z, input logic [2:0] exp_op);
    logic [3:0] exp_st [3];
    exp_st = '{4'd0, 4'd1, 4'd9};
    opcode = op; zero = z;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (state !== exp_st[i]) $display("FAIL br_state op=%b c%0d: got %0d want %0d", op, i, state, exp_st[i]);
      else pass_cnt++;
      total_cnt++;
      if (pc_en !== (i == 0 || (i == 2 && z)))
        $display("FAIL br_pcen op=%b z=%b c%0d: got %b want %b", op, z, i, pc_en, (i == 0 || (i == 2 && z)));
      else pass_cnt++;
      if (i == 2) begin
        total_cnt++;
        if (alu_op !== exp_op || pc_source !== 2'd1 || instr_done !== 1'b1)
          $display("FAIL br_exec op=%b: got aop=%b src=%0d done=%b want aop=%b src=1 done=1",
                   op, alu_op, pc_source, instr_done, exp_op);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [3:0] exp_st [3];
    exp_st = '{4'd0, 4'd1, 4'd10};
    opcode = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (state !== exp_st[i]) $display("FAIL j_state c%0d: got %0d want %0d", i, state, exp_st[i]);
      else pass_cnt++;
      if (i == 2) begin
        total_cnt++;
        if (pc_source !== 2'd2 || pc_en !== 1'b1 || instr_done !== 1'b1)
          $display("FAIL j_exec: got src=%0d pce=%b done=%b want src=2 pce=1 done=1", pc_source, pc_en, instr_done);
        else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] exp_st [2];
    exp_st = '{4'd0, 4'd1};
    opcode = 6'b111111;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (state !== exp_st[i] || instr_done !== (i == 1) || reg_write !== 1'b0 || mem_write !== 1'b0)
        $display("FAIL illegal c%0d: got st=%0d done=%b rw=%b mw=%b want st=%0d done=%b rw=0 mw=0",
                 i, state, instr_done, reg_write, mem_write, exp_st[i], (i == 1));
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (state !== 4'd0) $display("FAIL illegal_back: got %0d want 0", state); else pass_cnt++;
  endtask

  task automatic test_bad_funct();
    logic [3:0] exp_st [3];
    exp_st = '{4'd0, 4'd1, 4'd6};
    opcode = 6'b000000; funct = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (state !== exp_st[i] || instr_done !== (i == 2) || reg_write !== 1'b0)
        $display("FAIL badfn c%0d: got st=%0d done=%b rw=%b want st=%0d done=%b rw=0",
                 i, state, instr_done, reg_write, exp_st[i], (i == 2));
      else pass_cnt++;
      if (i == 2) begin
        total_cnt++;
        if (alu_op !== 3'b010) $display("FAIL badfn_aluop: got %b want 010", alu_op); else pass_cnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'b100011;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (state !== 4'd4 || reg_write !== 1'b1)
      $display("FAIL mid_pre: got st=%0d rw=%b want st=4 rw=1", state, reg_write);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (reg_write !== 1'b0 || state !== 4'd0 || instr_done !== 1'b0 || mem_read !== 1'b0)
      $display("FAIL mid_abort: got rw=%b st=%0d done=%b mr=%b want rw=0 st=0 done=0 mr=0",
               reg_write, state, instr_done, mem_read);
    else pass_cnt++;
    opcode = 6'b111111;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (state !== 4'd0 || mem_read !== 1'b1)
      $display("FAIL mid_refetch: got st=%0d mr=%b want st=0 mr=1", state, mem_read);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (state !== 4'd1) $display("FAIL mid_decode: got %0d want 1", state); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_r_sub();
    test_ori();
    test_branch(6'b000100, 1'b1, 3'b100);
    test_branch(6'b000100, 1'b0, 3'b100);
    test_branch(6'b000101, 1'b1, 3'b011);
    test_jump();
    test_illegal();
    test_bad_funct();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
